// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared encodings for the sequential radix-2 Booth multiplier
//
// Holds the FSM state encoding and the Booth operation codes. The op codes
// are indexed directly by {q[0], q_m1}, so a cast of that pair selects the op.
// Optional feature macro used by this bundle: BOOTH_ZERO_BYPASS_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 00 and 11 both pass A through; 01 adds M; 10 subtracts M.
  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2,
    OP_PASS2 = 2'd3
  } op_t;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration
//
// Ports:
//   a, q, q_m1, m   current partial-product state and sign-extended multiplicand
//   a_n, q_n, q_m1_n  state after the add/sub/pass select and arithmetic right shift
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_n,
  output logic [WIDTH-1:0] q_n,
  output logic             q_m1_n
);

  op_t            op;
  logic [WIDTH:0] a_sel;

  assign op = op_t'({q[0], q_m1});

  // 4:1 select of {A, A+M, A-M, A}; A and M are one bit wider than the
  // operands, so A-M with M = -2^(WIDTH-1) stays in range.
  always_comb begin
    a_sel = a;
    case (op)
      OP_PASS:  a_sel = a;
      OP_ADD:   a_sel = a + m;
      OP_SUB:   a_sel = a - m;
      OP_PASS2: a_sel = a;
      default:  a_sel = a;
    endcase
  end

  // Arithmetic shift right of {a_sel, q, q_m1}, replicating the a_sel MSB.
  assign a_n    = {a_sel[WIDTH], a_sel[WIDTH:1]};
  assign q_n    = {a_sel[0], q[WIDTH-1:1]};
  assign q_m1_n = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequential radix-2 Booth signed multiplier with start/done handshake
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          request, sampled only while ready=1
//   multiplicand   signed M, sampled at acceptance
//   multiplier     signed Q, sampled at acceptance
//   ready          high in IDLE or DONE
//   busy           high in RUN
//   done           one-cycle pulse in DONE, product valid
//   product        signed M*Q, held until the next DONE entry
// Optional feature: define BOOTH_ZERO_BYPASS_EN to skip iterations when
// either operand is zero (DONE the cycle after acceptance, product 0).
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state_q, state_d;

  logic [WIDTH:0]   a_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             q_m1_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   a_n;
  logic [WIDTH-1:0] q_n;
  logic             q_m1_n;

  logic load;
  logic last_iter;
  logic zero_ops;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q      (q_q),
    .q_m1   (q_m1_q),
    .m      (m_q),
    .a_n    (a_n),
    .q_n    (q_n),
    .q_m1_n (q_m1_n)
  );

  // cnt_q counts completed iterations; the WIDTH-th one happens when it reads WIDTH-1.
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BOOTH_ZERO_BYPASS_EN
  assign zero_ops = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_ops = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = zero_ops ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: begin
        // start in DONE reloads immediately; done still pulses this cycle.
        if (start) begin
          load    = 1'b1;
          state_d = zero_ops ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q    <= '0;
        m_q    <= {multiplicand[WIDTH-1], multiplicand};
        q_q    <= multiplier;
        q_m1_q <= 1'b0;
        cnt_q  <= '0;
        if (zero_ops) product <= '0;
      end else if (state_q == ST_RUN) begin
        a_q    <= a_n;
        q_q    <= q_n;
        q_m1_q <= q_m1_n;
        cnt_q  <= cnt_q + CNT_W'(1);
        // Product is captured from the final shift as DONE is entered.
        if (last_iter) product <= {a_n[WIDTH-1:0], q_n};
      end
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - directed testbench for booth_seq_ctrl
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        ready, busy, done;
  logic [31:0] product;

  int vecs = 0;
  int errs = 0;

  booth_seq_ctrl #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done after an accepting edge; returns edges waited and busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] m, input logic [15:0] q,
                     input logic [31:0] exp_p, input int exp_lat);
    int lat, bc;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start = 1'b0;
    if (exp_lat > 0) chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, bc, exp_lat);
    chk({tag, "_product"}, product, exp_p);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_held"}, product, exp_p);
  endtask

  initial begin
    int lat, bc, pulses, gap;
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    chk("reset_product", product, 32'd0);
    chk("reset_flags", {29'd0, ready, busy, done}, 32'b100);
    rst_n = 1'b1;
    tick();

    run("m3_qn4", 16'd3, 16'hFFFC, 32'hFFFF_FFF4, 16);
    run("min_min", 16'h8000, 16'h8000, 32'h4000_0000, 16);
    run("min_one", 16'h8000, 16'h0001, 32'hFFFF_8000, 16);

    // start while busy must be ignored
    multiplicand = 16'd7;
    multiplier   = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    multiplicand = 16'd5;
    multiplier   = 16'd5;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    wait_done(lat, bc);
    chk("busy_start_lat", lat + 9, 16);
    chk("busy_start_product", product, 32'd63);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("busy_start_pulses", pulses, 0);

    // reset in the middle of RUN
    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_product", product, 32'd0);
    chk("midrun_reset_flags", {29'd0, ready, busy, done}, 32'b100);
    tick();
    rst_n = 1'b1;
    tick();
    run("after_reset", 16'd2, 16'd3, 32'd6, 16);

    // back-to-back with start held through DONE
    multiplicand = 16'hFFFF;
    multiplier   = 16'hFFFF;
    start = 1'b1;
    tick();
    multiplicand = 16'd12;
    multiplier   = 16'hFFFB;
    wait_done(lat, bc);
    chk("b2b_first_lat", lat, 16);
    chk("b2b_first_product", product, 32'd1);
    tick();
    start = 1'b0;
    chk("b2b_reload_busy", {31'd0, busy}, 32'd1);
    wait_done(gap, bc);
    chk("b2b_gap", gap + 1, 17);
    chk("b2b_second_product", product, 32'hFFFF_FFC4);
    tick();
    chk("b2b_idle", {29'd0, ready, busy, done}, 32'b100);

`ifdef BOOTH_ZERO_BYPASS_EN
    run("zero_m", 16'd0, 16'd1234, 32'd0, 0);
`else
    run("zero_m", 16'd0, 16'd1234, 32'd0, 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
